// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM round-robin arbiter
package sram_arb_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   localparam logic CL_A = 1'b0;
   localparam logic CL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with its priority pointer
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (ptr == CL_A) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer moves to the client that lost (or did not ask) this round.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= CL_A;
      else if (advance)
         ptr <= grant[0] ? CL_B : CL_A;
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - serialises two clients' read/write commands onto one SRAM port
module sram_rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          sram_cs,
   output logic          sram_we,
   output logic          sram_rd,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout,
   output logic          busy
);

   state_t        state, state_nxt;
   logic [1:0]    arb_grant;
   logic [1:0]    gnt;
   logic          cmd_we;
   logic          cmd_owner;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({b_req, a_req}),
      .advance (|gnt),
      .grant   (arb_grant)
   );

   always_comb begin
      state_nxt = state;
      gnt       = 2'b00;
      sram_cs   = 1'b0;
      sram_we   = 1'b0;
      sram_rd   = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (|arb_grant)) begin
               gnt       = arb_grant;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // Strobes are masked in a reset cycle so an aborted write never commits.
            sram_cs   = ~rst;
            sram_we   = cmd_we & ~rst;
            sram_rd   = ~cmd_we & ~rst;
            state_nxt = cmd_we ? IDLE : RDWAIT;
         end
         RDWAIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign a_gnt     = gnt[0];
   assign b_gnt     = gnt[1];
   assign busy      = (state != IDLE);
   assign sram_addr = cmd_addr;
   assign sram_din  = cmd_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_we    <= 1'b0;
         cmd_owner <= CL_A;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
      end else begin
         state    <= state_nxt;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         if (|gnt) begin
            cmd_we    <= gnt[1] ? b_we    : a_we;
            cmd_addr  <= gnt[1] ? b_addr  : a_addr;
            cmd_wdata <= gnt[1] ? b_wdata : a_wdata;
            cmd_owner <= gnt[1] ? CL_B    : CL_A;
         end
         if (state == RDWAIT) begin
            if (cmd_owner == CL_B) begin
               b_rdata  <= sram_dout;
               b_rvalid <= 1'b1;
            end else begin
               a_rdata  <= sram_dout;
               a_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule
